// File: rtl/min_sec_counter.sv
// Stopwatch counting stage: self-timed 1 s prescaler, 00:00..59:59 count, run/pause/clear buttons.
// Optional lap-hold display snapshot is enabled by defining LAP_HOLD_EN.
module min_sec_counter #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_run_btn,
    input  logic       i_clear_btn,
`ifdef LAP_HOLD_EN
    input  logic       i_lap_btn,
`endif
    output logic [5:0] o_min,
    output logic [5:0] o_sec,
    output logic       o_running,
    output logic       o_wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [26:0] TICK_LAST = 27'(TICK_DIV - 1);

    state_t      state;
    logic [26:0] presc;
    logic [5:0]  min_cnt;
    logic [5:0]  sec_cnt;

    // {prev, sync2, sync1} per button
    logic [2:0]  run_sh;
    logic [2:0]  clr_sh;
    logic        run_edge;
    logic        clr_edge;

    assign run_edge = run_sh[1] & ~run_sh[2];
    assign clr_edge = clr_sh[1] & ~clr_sh[2];

`ifdef LAP_HOLD_EN
    logic [2:0]  lap_sh;
    logic        lap_edge;
    logic        hold;
    logic [5:0]  snap_min;
    logic [5:0]  snap_sec;

    assign lap_edge = lap_sh[1] & ~lap_sh[2];
    assign o_min    = hold ? snap_min : min_cnt;
    assign o_sec    = hold ? snap_sec : sec_cnt;
`else
    assign o_min    = min_cnt;
    assign o_sec    = sec_cnt;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state     <= IDLE;
            presc     <= '0;
            min_cnt   <= '0;
            sec_cnt   <= '0;
            o_running <= 1'b0;
            o_wrap    <= 1'b0;
            run_sh    <= '0;
            clr_sh    <= '0;
`ifdef LAP_HOLD_EN
            lap_sh    <= '0;
            hold      <= 1'b0;
            snap_min  <= '0;
            snap_sec  <= '0;
`endif
        end else begin
            run_sh <= {run_sh[1:0], i_run_btn};
            clr_sh <= {clr_sh[1:0], i_clear_btn};
`ifdef LAP_HOLD_EN
            lap_sh <= {lap_sh[1:0], i_lap_btn};
`endif
            o_wrap <= 1'b0;

            // Clear outranks a run edge arriving in the same cycle.
            if (clr_edge) begin
                state     <= IDLE;
                o_running <= 1'b0;
                presc     <= '0;
                min_cnt   <= '0;
                sec_cnt   <= '0;
`ifdef LAP_HOLD_EN
                hold      <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (run_edge) begin
                            state     <= RUN;
                            o_running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (run_edge) begin
                            state     <= PAUSE;
                            o_running <= 1'b0;
                        end
                        if (presc == TICK_LAST) begin
                            presc <= '0;
                            if (sec_cnt == 6'd59) begin
                                sec_cnt <= '0;
                                if (min_cnt == 6'd59) begin
                                    min_cnt <= '0;
                                    o_wrap  <= 1'b1;
                                end else begin
                                    min_cnt <= min_cnt + 6'd1;
                                end
                            end else begin
                                sec_cnt <= sec_cnt + 6'd1;
                            end
                        end else begin
                            presc <= presc + 27'd1;
                        end
`ifdef LAP_HOLD_EN
                        // Snapshot captures the value on display before this edge.
                        if (lap_edge) begin
                            hold <= ~hold;
                            if (!hold) begin
                                snap_min <= min_cnt;
                                snap_sec <= sec_cnt;
                            end
                        end
`endif
                    end
                    PAUSE: begin
                        if (run_edge) begin
                            state     <= RUN;
                            o_running <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        o_running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_min_sec_counter.sv
// Directed self-checking bench for min_sec_counter with TICK_DIV = 4.
// Lap steps are compiled in only when LAP_HOLD_EN is defined.
module tb_min_sec_counter;

    logic       clk;
    logic       rst_n;
    logic       run_btn;
    logic       clear_btn;
    logic       lap_btn;
    logic [5:0] min_v;
    logic [5:0] sec_v;
    logic       running;
    logic       wrap;

    int errors = 0;
    int checks = 0;

    min_sec_counter #(.TICK_DIV(4)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_run_btn   (run_btn),
        .i_clear_btn (clear_btn),
`ifdef LAP_HOLD_EN
        .i_lap_btn   (lap_btn),
`endif
        .o_min       (min_v),
        .o_sec       (sec_v),
        .o_running   (running),
        .o_wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-cycle pulse on the selected buttons; returns just after the edge
    // on which the design acts on it (two edges after first sampling).
    task automatic pulse(input logic r, input logic c, input logic l);
        run_btn   = r;
        clear_btn = c;
        lap_btn   = l;
        tick(1);
        run_btn   = 1'b0;
        clear_btn = 1'b0;
        lap_btn   = 1'b0;
        tick(2);
    endtask

    initial begin
        rst_n     = 1'b0;
        run_btn   = 1'b0;
        clear_btn = 1'b0;
        lap_btn   = 1'b0;

        // Reset
        tick(3);
        check("rst_min", 32'(min_v), 0);
        check("rst_sec", 32'(sec_v), 0);
        check("rst_running", 32'(running), 0);
        check("rst_wrap", 32'(wrap), 0);
        rst_n = 1'b1;
        tick(40);
        check("idle_sec", 32'(sec_v), 0);
        check("idle_running", 32'(running), 0);

        // Start: button held 3 cycles still gives a single toggle
        run_btn = 1'b1;
        tick(2);
        check("start_lat_n1", 32'(running), 0);
        tick(1);
        check("start_lat_n2", 32'(running), 1);
        run_btn = 1'b0;
        tick(3);
        check("first_sec_e3", 32'(sec_v), 0);
        tick(1);
        check("first_sec_e4", 32'(sec_v), 1);
        for (int k = 2; k <= 5; k++) begin
            tick(4);
            check("count_sec", 32'(sec_v), 32'(k));
        end
        check("held_btn_still_run", 32'(running), 1);

        // Pause: prescaler reaches 3 on the pause edge
        pulse(1'b1, 1'b0, 1'b0);
        check("pause_running", 32'(running), 0);
        check("pause_sec", 32'(sec_v), 5);
        tick(50);
        check("pause_hold_sec", 32'(sec_v), 5);
        pulse(1'b1, 1'b0, 1'b0);
        check("resume_running", 32'(running), 1);
        check("resume_sec", 32'(sec_v), 5);
        tick(1);
        check("resume_partial", 32'(sec_v), 6);
        tick(4);
        check("resume_next", 32'(sec_v), 7);

        // Simultaneous run + clear at 00:07
        run_btn   = 1'b1;
        clear_btn = 1'b1;
        tick(1);
        run_btn   = 1'b0;
        clear_btn = 1'b0;
        tick(1);
        check("simul_pre_sec", 32'(sec_v), 7);
        tick(1);
        check("simul_sec", 32'(sec_v), 0);
        check("simul_min", 32'(min_v), 0);
        check("simul_running", 32'(running), 0);
        tick(10);
        check("simul_stays_idle", 32'(sec_v), 0);

        // Rollover from 00:00
        pulse(1'b1, 1'b0, 1'b0);
        tick(239);
        check("roll_0059_min", 32'(min_v), 0);
        check("roll_0059_sec", 32'(sec_v), 59);
        tick(1);
        check("roll_0100_min", 32'(min_v), 1);
        check("roll_0100_sec", 32'(sec_v), 0);
        tick(4 * 3600 - 1 - 240);
        check("roll_5959", 32'({min_v, sec_v}), 32'({6'd59, 6'd59}));
        check("roll_wrap_pre", 32'(wrap), 0);
        tick(1);
        check("roll_0000", 32'({min_v, sec_v}), 0);
        check("roll_wrap", 32'(wrap), 1);
        check("roll_running", 32'(running), 1);
        tick(1);
        check("roll_wrap_one", 32'(wrap), 0);
        tick(3);
        check("roll_continue", 32'(sec_v), 1);

        // Clear while running
        pulse(1'b0, 1'b1, 1'b0);
        check("clear_count", 32'({min_v, sec_v}), 0);
        check("clear_running", 32'(running), 0);
        tick(10);
        check("clear_idle", 32'(sec_v), 0);

`ifdef LAP_HOLD_EN
        // Lap in IDLE is ignored; lap at 00:03 holds, second lap shows live 00:06
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        tick(12);
        check("lap_pre_sec", 32'(sec_v), 3);
        pulse(1'b0, 1'b0, 1'b1);
        check("lap_hold_now", 32'(sec_v), 3);
        tick(8);
        check("lap_hold_sec", 32'(sec_v), 3);
        check("lap_hold_min", 32'(min_v), 0);
        pulse(1'b0, 1'b0, 1'b1);
        check("lap_release", 32'(sec_v), 6);
        pulse(1'b0, 1'b1, 1'b0);
        check("lap_clear", 32'(sec_v), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/min_sec_counter.md
# min_sec_counter

Stopwatch counting stage for the FND counter display. It generates its own 1 s timebase from the system clock and counts minutes and seconds from 00:00 to 59:59. Start/pause and clear are controlled by push buttons. It sits directly upstream of the digit divider: the 6-bit minute and second outputs feed that stage's two binary inputs, and the four BCD digits are produced downstream.

## Interface
- `TICK_DIV`, default 100_000_000: system clocks per counted second; legal range 2..2^27.
- `i_clk`, input, 1: system clock; all logic on the rising edge.
- `i_reset`, input, 1: synchronous, active-low reset.
- `i_run_btn`, input, 1: asynchronous push button; each rising edge toggles run/pause.
- `i_clear_btn`, input, 1: asynchronous push button; a rising edge clears the count.
- `i_lap_btn`, input, 1: asynchronous push button; present only with `LAP_HOLD_EN`.
- `o_min`, output, 6: minutes, 0..59, unsigned binary.
- `o_sec`, output, 6: seconds, 0..59, unsigned binary.
- `o_running`, output, 1: high in the RUN state.
- `o_wrap`, output, 1: one-cycle pulse when the count rolls over from 59:59 to 00:00.

## Operation
- **Button conditioning.** Each button passes through a 2-flop synchronizer and then a rising-edge detector (`sync2 & ~prev`). A held button produces exactly one event.
- **FSM states.** IDLE (count zero, stopped), RUN, PAUSE (count held).
  - IDLE + run edge -> RUN.
  - RUN + run edge -> PAUSE.
  - PAUSE + run edge -> RUN.
  - Any state + clear edge -> IDLE; min, sec and prescaler are zeroed.
- **Simultaneous events.** A clear edge and a run edge in the same cycle resolve to clear: the next state is IDLE.
- **Prescaler.**
  - 27-bit counter that increments only in RUN.
  - At `TICK_DIV-1` it returns to 0 and the seconds counter advances.
  - Holds its value in PAUSE, so resume continues the partial second.
  - Zeroed in IDLE.
- **Seconds advance.** sec 0..58 -> sec+1. sec 59 -> sec 0 and min advances.
- **Minutes advance.** min 0..58 -> min+1. min 59 with sec 59 -> 00:00, `o_wrap` pulses, and the state stays RUN.
- **Width rule.** min and sec never leave 0..59; values 60..63 are unreachable.
- **Reset** (`i_reset` low at a clock edge):
  - state -> IDLE;
  - `o_min` = 0, `o_sec` = 0, `o_running` = 0, `o_wrap` = 0;
  - prescaler and synchronizers -> 0;
  - hold flag -> 0.
- **Reset mid-count** discards the count entirely; it has the same effect as power-up.

## Timing
- **Button latency.** If a button is first sampled high at edge N, the state/count update occurs at edge N+2.
- **Registered outputs.** All outputs are registered; `o_running` changes on the same edge as the state.
- **First second.** Entering RUN from IDLE at edge E puts the first increment of `o_sec` at edge E+`TICK_DIV`. Each subsequent increment follows every `TICK_DIV` cycles while in RUN.
- **Pause and resume.** Pausing after k prescaler counts and then resuming means the next increment takes `TICK_DIV`-k RUN cycles.
- **`o_wrap`.** High for exactly the one cycle following the edge on which 59:59 -> 00:00.
- **No handshake downstream.** The digit divider samples `o_min`/`o_sec` continuously.

## Configuration
- **`LAP_HOLD_EN` defined:**
  - Adds `i_lap_btn`, conditioned the same way as the other buttons.
  - A lap edge in RUN sets the hold flag and latches a snapshot of min/sec; `o_min`/`o_sec` show the snapshot while the internal count keeps running.
  - A second lap edge clears hold, and the outputs show the live count from the next edge.
  - Lap edges in IDLE or PAUSE are ignored.
  - Hold persists through PAUSE/RUN transitions.
  - Clear or reset drops hold.
  - `o_wrap` always reflects the live count.
- **`LAP_HOLD_EN` undefined:** the port, snapshot registers and hold flag are absent, and the outputs always show the live count.

## Test plan
- **Reset.** Use `TICK_DIV`=4 and hold `i_reset` low for 3 cycles. Expect min=0, sec=0, `o_running`=0, `o_wrap`=0; 40 idle cycles produce no change.
- **Start and count.**
  - Stimulus: run pulse, then 20 cycles.
  - Expect `o_running` high 2 edges after the button.
  - Expect sec to step 1, 2, 3, 4, 5 every 4 cycles.
- **Pause and clear.**
  - Stimulus: run, 6 cycles, run again (pause), wait 50 cycles, run again.
  - Expect sec to hold during the pause and the next increment after 4-(partial) cycles.
  - Then a clear pulse: expect 00:00, `o_running`=0, IDLE.
- **Rollover.** Run 3600×4 cycles from 00:00. Expect 00:59 -> 01:00, then 59:59 -> 00:00 with a one-cycle `o_wrap`, and the counter stays running.
- **Simultaneous run and clear** in the same cycle during RUN at 00:07: expect 00:00 and IDLE.
- **Lap (`LAP_HOLD_EN`).**
  - Stimulus: lap at 00:03, then 12 more cycles.
  - Expect the outputs to stay at 00:03.
  - Second lap: expect 00:06 shown.
